hilo_file: RTL and testbench
============================

Name: hilo_file

Overview:
- Parametrised HI/LO architectural register pair for the multi-issue integer pipeline.
- Accepts same-cycle writes from LANES commit lanes; the highest lane index is youngest and wins.
- Tracks in-flight long-latency mul/div ops with a pending counter and busy flag.
- Provides registered outputs plus next-state forwarding outputs for the issue stage.

Parameters:
LANES, 2, number of commit lanes (1..4); lane 0 is the oldest
WIDTH, 32, data width of HI and of LO
MAX_PEND, 3, maximum outstanding long-latency ops (1..7); the counter width is derived locally

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hi_we  in  LANES  per-lane HI write enable
lo_we  in  LANES  per-lane LO write enable
hi_wdata  in  LANES*WIDTH  per-lane HI data; lane k is at [k*WIDTH +: WIDTH]
lo_wdata  in  LANES*WIDTH  per-lane LO data, same packing
long_issue  in  1  one long-latency op dispatched this cycle
long_done  in  1  oldest long op completes this cycle; writes both HI and LO
long_hi  in  WIDTH  long-op HI result
long_lo  in  WIDTH  long-op LO result
flush  in  1  pipeline flush; the mul/div unit is cancelled by the same signal
hi_o  out  WIDTH  registered HI
lo_o  out  WIDTH  registered LO
hi_fwd  out  WIDTH  combinational value HI takes at the next edge
lo_fwd  out  WIDTH  combinational value LO takes at the next edge
busy  out  1  pend_cnt != 0
pend_cnt  out  derived  outstanding long-op count
ovf_err  out  1  sticky error: issue at full count or done at zero

Behaviour:
- Reset (async, rst_n low): hi_o=0, lo_o=0, pend_cnt=0, ovf_err=0. Takes effect immediately, including mid-operation; first update on the first rising edge after rst_n goes high.
- HI and LO are resolved independently each cycle. Priority, highest first:
  - Highest-index lane with its we asserted.
  - Accumulate (optional feature only).
  - long_done, if accepted.
  - Hold.
- HI and LO may therefore come from different sources in one cycle, e.g. lane 1 writes HI while long_done writes LO.
- Write latency: one cycle. Data driven in cycle N appears on hi_o/lo_o after edge N.
- hi_fwd/lo_fwd equal the resolved next value, i.e. hi_o/lo_o of cycle N+1. They are purely combinational from the inputs and current state.
- Pending counter, per cycle:
  - flush=1: pend_cnt <= 0; long_issue and long_done are ignored; lane writes still commit (upstream deasserts we for squashed lanes).
  - Otherwise, acc_issue = long_issue & (pend_cnt<MAX_PEND | long_done) and acc_done = long_done & pend_cnt!=0.
  - pend_cnt <= pend_cnt + acc_issue - acc_done.
  - Simultaneous issue and done at full count: the count stays at MAX_PEND and both are accepted.
- Rejected issue (full, no done) or rejected done (count 0, no issue) sets ovf_err and is dropped. A rejected done does not write HI/LO and leaves the count unchanged. ovf_err clears only on reset.
- long_done with pend_cnt=0 and long_issue=1 in the same cycle is a rejected done: ovf_err=1, no HI/LO write, pend_cnt becomes 1.
- busy is combinational from pend_cnt.

Optional Feature:
Macro HILO_ACC_EN.
- Defined:
  - Adds inputs acc_valid (1), acc_sub (1) and acc_prod (2*WIDTH).
  - When acc_valid=1, {HI,LO} <= {hi_o,lo_o} ± acc_prod (subtract when acc_sub=1), with modulo 2^(2*WIDTH) wrap and no overflow flag.
  - Priority is below lane writes and above long_done. A lane write to only HI still lets acc supply LO.
  - acc_valid is ignored during flush.
- Undefined: the ports are absent and the priority chain is lanes then long_done.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle after HI=0x1234 -> hi_o, lo_o and pend_cnt read 0 before the next edge.
- hi_we=2'b11, lane0 HI=0xAAAA0000, lane1 HI=0x5555FFFF -> hi_fwd=0x5555FFFF that cycle and hi_o=0x5555FFFF next cycle; LO unchanged.
- long_done with long_hi=0x1, long_lo=0x2 plus lo_we[0]=1 with lo=0x9 (pend_cnt=1) -> hi_o=0x1, lo_o=0x9, pend_cnt=0, busy=0.
- Issue 3 ops (MAX_PEND=3), then issue+done together, then a lone issue -> pend_cnt 3, 3, 3 and ovf_err=1 after the third step.
- pend_cnt=2 with flush=1, long_done=1 and hi_we[0]=1 (0x77) -> pend_cnt=0, hi_o=0x77, LO not written by long_done.
- HILO_ACC_EN: HI=0, LO=0xFFFFFFFF, acc_valid=1, acc_sub=0, acc_prod=1 -> HI=0x1, LO=0x0; then acc_sub=1, acc_prod=2 -> HI=0x0, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/hilo_file.sv
// hilo_file: HI/LO architectural register pair for the multi-issue integer pipe.
// Same-cycle commits from LANES lanes (highest index wins), long-latency
// mul/div completion tracking with a saturating pending counter and a sticky
// protocol error flag. Next-state values are exported for issue-stage bypass.
//
// Optional feature macro: HILO_ACC_EN adds a {HI,LO} +/- product accumulate
// path (inputs acc_valid, acc_sub, acc_prod) ranked between lane writes and
// long_done.
module hilo_file #(
  parameter int LANES    = 2,
  parameter int WIDTH    = 32,
  parameter int MAX_PEND = 3,
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       hi_we,
  input  logic [LANES-1:0]       lo_we,
  input  logic [LANES*WIDTH-1:0] hi_wdata,
  input  logic [LANES*WIDTH-1:0] lo_wdata,
  input  logic                   long_issue,
  input  logic                   long_done,
  input  logic [WIDTH-1:0]       long_hi,
  input  logic [WIDTH-1:0]       long_lo,
  input  logic                   flush,
`ifdef HILO_ACC_EN
  input  logic                   acc_valid,
  input  logic                   acc_sub,
  input  logic [2*WIDTH-1:0]     acc_prod,
`endif
  output logic [WIDTH-1:0]       hi_o,
  output logic [WIDTH-1:0]       lo_o,
  output logic [WIDTH-1:0]       hi_fwd,
  output logic [WIDTH-1:0]       lo_fwd,
  output logic                   busy,
  output logic [CW-1:0]          pend_cnt,
  output logic                   ovf_err
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             issue_ok;
  logic             done_ok;

  // Pending counter: accept/reject issue and done, flush clears the count.
  always_comb begin
    issue_ok = 1'b0;
    done_ok  = 1'b0;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      // A done in the same cycle frees a slot, so a full counter still takes the issue.
      issue_ok = long_issue & ((pend_q < CW'(MAX_PEND)) | long_done);
      done_ok  = long_done & (pend_q != '0);
      if ((long_issue & ~issue_ok) | (long_done & ~done_ok)) begin
        ovf_d = 1'b1;
      end
      pend_d = pend_q + CW'(issue_ok) - CW'(done_ok);
    end
  end

`ifdef HILO_ACC_EN
  logic [2*WIDTH-1:0] acc_sum;

  // Accumulate result, wrapping modulo 2^(2*WIDTH).
  always_comb begin
    if (acc_sub) begin
      acc_sum = {hi_q, lo_q} - acc_prod;
    end else begin
      acc_sum = {hi_q, lo_q} + acc_prod;
    end
  end
`endif

  // HI and LO next value, lowest priority first so later assignments win.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done_ok) begin
      hi_d = long_hi;
      lo_d = long_lo;
    end
`ifdef HILO_ACC_EN
    if (acc_valid & ~flush) begin
      hi_d = acc_sum[2*WIDTH-1:WIDTH];
      lo_d = acc_sum[WIDTH-1:0];
    end
`endif
    // Ascending scan leaves the youngest (highest-index) lane's data in place.
    for (int k = 0; k < LANES; k++) begin
      if (hi_we[k]) hi_d = hi_wdata[k*WIDTH +: WIDTH];
      if (lo_we[k]) lo_d = lo_wdata[k*WIDTH +: WIDTH];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign hi_fwd   = hi_d;
  assign lo_fwd   = lo_d;
  assign pend_cnt = pend_q;
  assign busy     = (pend_q != '0);
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_hilo_file.sv
// Bench for hilo_file: an independent next-state model pushes the expected
// post-edge state into a queue when stimulus is applied; each scenario pops
// and compares after the edge, and also checks the forwarding outputs.
module tb_hilo_file;

  localparam int LANES    = 2;
  localparam int WIDTH    = 32;
  localparam int MAX_PEND = 3;
  localparam int CW       = 2;
  localparam int EW       = 2*WIDTH + CW + 2;

  logic                   clk;
  logic                   rst_n;
  logic [LANES-1:0]       hi_we, lo_we;
  logic [LANES*WIDTH-1:0] hi_wdata, lo_wdata;
  logic                   long_issue, long_done;
  logic [WIDTH-1:0]       long_hi, long_lo;
  logic                   flush;
`ifdef HILO_ACC_EN
  logic                   acc_valid, acc_sub;
  logic [2*WIDTH-1:0]     acc_prod;
`endif
  logic [WIDTH-1:0]       hi_o, lo_o, hi_fwd, lo_fwd;
  logic                   busy, ovf_err;
  logic [CW-1:0]          pend_cnt;

  hilo_file #(.LANES(LANES), .WIDTH(WIDTH), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .long_issue(long_issue), .long_done(long_done),
    .long_hi(long_hi), .long_lo(long_lo), .flush(flush),
`ifdef HILO_ACC_EN
    .acc_valid(acc_valid), .acc_sub(acc_sub), .acc_prod(acc_prod),
`endif
    .hi_o(hi_o), .lo_o(lo_o), .hi_fwd(hi_fwd), .lo_fwd(lo_fwd),
    .busy(busy), .pend_cnt(pend_cnt), .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Model state.
  logic [WIDTH-1:0] m_hi, m_lo;
  int               m_cnt;
  logic             m_ovf;
  logic [WIDTH-1:0] exp_hi_fwd, exp_lo_fwd;

  logic [EW-1:0] sb[$];
  logic [EW-1:0] got, exp_v;

  task automatic idle_inputs();
    hi_we = '0; lo_we = '0; hi_wdata = '0; lo_wdata = '0;
    long_issue = 1'b0; long_done = 1'b0; long_hi = '0; long_lo = '0;
    flush = 1'b0;
`ifdef HILO_ACC_EN
    acc_valid = 1'b0; acc_sub = 1'b0; acc_prod = '0;
`endif
  endtask

  task automatic model_clear();
    m_hi = '0; m_lo = '0; m_cnt = 0; m_ovf = 1'b0;
    sb.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Computes the expected next state from current inputs and model state,
  // pushes it, and advances the model.
  task automatic predict();
    logic [WIDTH-1:0] nh, nl;
    logic [2*WIDTH-1:0] pair;
    int c;
    logic ov, take_issue, take_done, hi_hit, lo_hit;
    nh = m_hi; nl = m_lo; c = m_cnt; ov = m_ovf;
    if (flush) begin
      c = 0;
    end else begin
      take_done  = long_done && (m_cnt != 0);
      take_issue = long_issue && ((m_cnt < MAX_PEND) || long_done);
      if (long_done && !take_done) ov = 1'b1;
      if (long_issue && !take_issue) ov = 1'b1;
      if (take_done) begin nh = long_hi; nl = long_lo; end
      c = m_cnt + (take_issue ? 1 : 0) - (take_done ? 1 : 0);
`ifdef HILO_ACC_EN
      if (acc_valid) begin
        pair = acc_sub ? ({m_hi, m_lo} - acc_prod) : ({m_hi, m_lo} + acc_prod);
        nh = pair[2*WIDTH-1:WIDTH];
        nl = pair[WIDTH-1:0];
      end
`endif
    end
    hi_hit = 1'b0; lo_hit = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (!hi_hit && hi_we[k]) begin nh = hi_wdata[k*WIDTH +: WIDTH]; hi_hit = 1'b1; end
      if (!lo_hit && lo_we[k]) begin nl = lo_wdata[k*WIDTH +: WIDTH]; lo_hit = 1'b1; end
    end
    exp_hi_fwd = nh; exp_lo_fwd = nl;
    sb.push_back({nh, nl, CW'(c), ov, (c != 0)});
    m_hi = nh; m_lo = nl; m_cnt = c; m_ovf = ov;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({hi_o, lo_o, pend_cnt, ovf_err, busy} !== '0) begin
      n_errs++; $display("FAIL reset_init: got=%h exp=0", {hi_o, lo_o, pend_cnt, ovf_err, busy});
    end
    @(posedge clk); #2 rst_n = 1'b1;
    model_clear();
    // Load HI=0x1234 and one pending op, then reset mid-cycle.
    hi_we = 2'b01; hi_wdata = {32'h0, 32'h1234}; long_issue = 1'b1;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL reset_load: got=%h exp=%h", got, exp_v); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || pend_cnt !== 2'd0 || busy !== 1'b0) begin
      n_errs++; $display("FAIL reset_async: got hi=%h lo=%h cnt=%0d exp 0/0/0", hi_o, lo_o, pend_cnt);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_lane_priority();
    lo_we = 2'b01; lo_wdata = {32'h0, 32'h0000CAFE};
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL lane_lo_setup: got=%h exp=%h", got, exp_v); end
    hi_we = 2'b11; hi_wdata = {32'h5555FFFF, 32'hAAAA0000};
    predict(); #1;
    n_checks++;
    if (hi_fwd !== 32'h5555FFFF || lo_fwd !== 32'h0000CAFE) begin
      n_errs++; $display("FAIL lane_fwd: got hi=%h lo=%h exp 5555ffff/0000cafe", hi_fwd, lo_fwd);
    end
    tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL lane_prio: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (hi_o !== 32'h5555FFFF || lo_o !== 32'h0000CAFE) begin
      n_errs++; $display("FAIL lane_prio_const: got hi=%h lo=%h exp 5555ffff/0000cafe", hi_o, lo_o);
    end
  endtask

  task automatic test_long_done_mix();
    long_issue = 1'b1;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL mix_issue: got=%h exp=%h", got, exp_v); end
    long_done = 1'b1; long_hi = 32'h1; long_lo = 32'h2;
    lo_we = 2'b01; lo_wdata = {32'h0, 32'h9};
    predict(); #1;
    n_checks++;
    if (hi_fwd !== exp_hi_fwd || lo_fwd !== exp_lo_fwd) begin
      n_errs++; $display("FAIL mix_fwd: got hi=%h lo=%h exp %h/%h", hi_fwd, lo_fwd, exp_hi_fwd, exp_lo_fwd);
    end
    tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL mix_done: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h9 || pend_cnt !== 2'd0 || busy !== 1'b0) begin
      n_errs++; $display("FAIL mix_const: got hi=%h lo=%h cnt=%0d busy=%b exp 1/9/0/0", hi_o, lo_o, pend_cnt, busy);
    end
  endtask

  task automatic test_pend_sat();
    for (int i = 0; i < 3; i++) begin
      long_issue = 1'b1;
      predict(); tick(); idle_inputs();
      got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin n_errs++; $display("FAIL sat_fill%0d: got=%h exp=%h", i, got, exp_v); end
    end
    long_issue = 1'b1; long_done = 1'b1; long_hi = 32'h10; long_lo = 32'h20;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL sat_both: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (pend_cnt !== 2'd3 || ovf_err !== 1'b0 || hi_o !== 32'h10) begin
      n_errs++; $display("FAIL sat_both_const: got cnt=%0d ovf=%b hi=%h exp 3/0/10", pend_cnt, ovf_err, hi_o);
    end
    long_issue = 1'b1;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL sat_over: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (pend_cnt !== 2'd3 || ovf_err !== 1'b1) begin
      n_errs++; $display("FAIL sat_over_const: got cnt=%0d ovf=%b exp 3/1", pend_cnt, ovf_err);
    end
  endtask

  task automatic test_flush();
    long_done = 1'b1; long_hi = 32'h30; long_lo = 32'h40;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL flush_pre: got=%h exp=%h", got, exp_v); end
    flush = 1'b1; long_done = 1'b1; long_hi = 32'hBEEF; long_lo = 32'hDEAD;
    hi_we = 2'b01; hi_wdata = {32'h0, 32'h77};
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL flush: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (pend_cnt !== 2'd0 || hi_o !== 32'h77 || lo_o !== 32'h40) begin
      n_errs++; $display("FAIL flush_const: got cnt=%0d hi=%h lo=%h exp 0/77/40", pend_cnt, hi_o, lo_o);
    end
  endtask

  task automatic test_reject_done();
    apply_reset();
    hi_we = 2'b01; hi_wdata = {32'h0, 32'hABC};
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL rej_setup: got=%h exp=%h", got, exp_v); end
    long_done = 1'b1; long_issue = 1'b1; long_hi = 32'hFFFF; long_lo = 32'hEEEE;
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL rej_done: got=%h exp=%h", got, exp_v); end
    n_checks++;
    if (hi_o !== 32'hABC || lo_o !== 32'h0 || pend_cnt !== 2'd1 || ovf_err !== 1'b1) begin
      n_errs++; $display("FAIL rej_done_const: got hi=%h lo=%h cnt=%0d ovf=%b exp abc/0/1/1", hi_o, lo_o, pend_cnt, ovf_err);
    end
  endtask

`ifdef HILO_ACC_EN
  task automatic test_acc();
    apply_reset();
    lo_we = 2'b01; lo_wdata = {32'h0, 32'hFFFFFFFF};
    predict(); tick(); idle_inputs();
    got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
    n_checks++;
    if (got !== exp_v) begin n_errs++; $display("FAIL acc_setup: got=%h exp=%h", got, exp_v); end
    acc_valid = 1'b1; acc_sub = 1'b0; acc_prod = 64'h1;
    predict(); tick(); idle_inputs();
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h0) begin
      n_errs++; $display("FAIL acc_add: got hi=%h lo=%h exp 1/0", hi_o, lo_o);
    end
    void'(sb.pop_front());
    acc_valid = 1'b1; acc_sub = 1'b1; acc_prod = 64'h2;
    predict(); tick(); idle_inputs();
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'hFFFFFFFE) begin
      n_errs++; $display("FAIL acc_sub: got hi=%h lo=%h exp 0/fffffffe", hi_o, lo_o);
    end
    void'(sb.pop_front());
    acc_valid = 1'b1; acc_sub = 1'b0; acc_prod = 64'h1;
    hi_we = 2'b10; hi_wdata = {32'h5, 32'h0};
    predict(); tick(); idle_inputs();
    n_checks++;
    if (hi_o !== 32'h5 || lo_o !== 32'hFFFFFFFF) begin
      n_errs++; $display("FAIL acc_lane_mix: got hi=%h lo=%h exp 5/ffffffff", hi_o, lo_o);
    end
    void'(sb.pop_front());
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      hi_we = LANES'($urandom_range(0, 3));
      lo_we = LANES'($urandom_range(0, 3));
      hi_wdata = {$urandom(), $urandom()};
      lo_wdata = {$urandom(), $urandom()};
      long_issue = ($urandom_range(0, 2) == 0);
      long_done = ($urandom_range(0, 2) == 0);
      long_hi = $urandom(); long_lo = $urandom();
      flush = ($urandom_range(0, 9) == 0);
`ifdef HILO_ACC_EN
      acc_valid = ($urandom_range(0, 3) == 0);
      acc_sub = $urandom_range(0, 1);
      acc_prod = {$urandom(), $urandom()};
`endif
      predict(); #1;
      n_checks++;
      if (hi_fwd !== exp_hi_fwd || lo_fwd !== exp_lo_fwd) begin
        n_errs++; $display("FAIL rand_fwd%0d: got hi=%h lo=%h exp %h/%h", i, hi_fwd, lo_fwd, exp_hi_fwd, exp_lo_fwd);
      end
      tick(); idle_inputs();
      got = {hi_o, lo_o, pend_cnt, ovf_err, busy}; exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin n_errs++; $display("FAIL rand_state%0d: got=%h exp=%h", i, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_lane_priority();
    test_long_done_mix();
    test_pend_sat();
    test_flush();
    test_reject_done();
`ifdef HILO_ACC_EN
    test_acc();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
